// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline's cache miss controllers.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITEBACK = 3'd1,
    ST_TURN      = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_REFILL    = 3'd4
  } dcache_state_t;

  localparam int unsigned DCACHE_TIMEOUT = 255;

endpackage

// File: rtl/dcache_timeout_cnt.sv
// Wait-cycle counter with a sticky flag raised when the count reaches LIMIT.
module dcache_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic flag_o
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          flag_d, flag_q;

  // Count saturates at LIMIT; clear has priority over enable.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == LIM) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/dcache_stall_ctrl.sv
// Data-cache miss controller: sequences writeback/allocate over the off-chip
// handshake and freezes the pipeline while a miss is serviced.
module dcache_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = DCACHE_TIMEOUT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_req_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic             victim_sel_o,
  output logic             cache_we_o,
  output logic             error_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  dcache_state_t    state_d, state_q;
  logic [CNT_W-1:0] miss_cnt_d, miss_cnt_q;
  logic             mem_enable_d, mem_enable_q;
  logic             mem_write_d, mem_write_q;
  logic             victim_sel_d, victim_sel_q;
  logic             cache_we_d, cache_we_q;
  logic             miss;
  logic             waiting;

  assign miss    = (state_q == ST_IDLE) && mem_req_i && !hit_i;
  assign waiting = (state_q == ST_WRITEBACK) || (state_q == ST_ALLOCATE);

  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d    = dirty_i ? ST_WRITEBACK : ST_ALLOCATE;
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      ST_WRITEBACK: if (mem_ack_i) state_d = ST_TURN;
      ST_TURN:      state_d = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Moore outputs are registered by decoding the next state.
    mem_enable_d = (state_d == ST_WRITEBACK) || (state_d == ST_ALLOCATE);
    mem_write_d  = (state_d == ST_WRITEBACK);
    victim_sel_d = (state_d == ST_WRITEBACK);
    cache_we_d   = (state_d == ST_REFILL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      miss_cnt_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      victim_sel_q <= 1'b0;
      cache_we_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_cnt_q   <= miss_cnt_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      victim_sel_q <= victim_sel_d;
      cache_we_q   <= cache_we_d;
    end
  end

  dcache_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(!waiting),
    .en_i   (waiting && !mem_ack_i),
    .flag_o (error_o)
  );

  // The IDLE term is combinational so MEM_WB never captures a missing access.
  assign stall_o      = (state_q != ST_IDLE) || miss;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign victim_sel_o = victim_sel_q;
  assign cache_we_o   = cache_we_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Scoreboard bench for dcache_stall_ctrl: each miss is planned up front and its
// expected cycle-by-cycle outputs are queued, then checked by a monitor.
module tb_dcache_stall_ctrl;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst, req, hit, dirty, ack;
  logic          stall_o, mem_enable_o, mem_write_o, victim_sel_o, cache_we_o, error_o;
  logic [CW-1:0] miss_cnt_o;

  always #5 clk = ~clk;

  dcache_stall_ctrl #(
    .TIMEOUT(TMO),
    .CNT_W  (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_req_i   (req),
    .hit_i       (hit),
    .dirty_i     (dirty),
    .mem_ack_i   (ack),
    .stall_o     (stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .victim_sel_o(victim_sel_o),
    .cache_we_o  (cache_we_o),
    .error_o     (error_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  typedef struct packed {
    logic          stall;
    logic          en;
    logic          wr;
    logic          vs;
    logic          we;
    logic          err;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  obs_t  act;
  int    errors = 0;
  int    checks = 0;
  bit    exp_err = 1'b0;
  int    exp_cnt = 0;

  assign act = {stall_o, mem_enable_o, mem_write_o, victim_sel_o, cache_we_o, error_o, miss_cnt_o};

  always @(negedge clk) begin
    obs_t  e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got stall=%b en=%b wr=%b vsel=%b we=%b err=%b cnt=%0d, expected stall=%b en=%b wr=%b vsel=%b we=%b err=%b cnt=%0d",
                 n, $time, act.stall, act.en, act.wr, act.vs, act.we, act.err, act.cnt,
                 e.stall, e.en, e.wr, e.vs, e.we, e.err, e.cnt);
      end
    end
  end

  function automatic obs_t mk(input bit s, input bit en, input bit wr, input bit vs, input bit we);
    logic [CW-1:0] c;
    c = CW'(exp_cnt);
    return {s, en, wr, vs, we, exp_err, c};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input bit r, input bit q, input bit h, input bit d, input bit a,
                     input obs_t e, input string nm);
    rst   = r;
    req   = q;
    hit   = h;
    dirty = d;
    ack   = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // No-miss cycle: either no access, or an access that hits.
  task automatic idle_cyc(input bit spur, input string nm);
    bit q;
    q = rb();
    cyc(1'b0, q, q ? 1'b1 : rb(), rb(), spur ? rb() : 1'b0, mk(0, 0, 0, 0, 0), nm);
  endtask

  // One miss: nwb writeback cycles (if dirty), nal allocate cycles, ack on the
  // last cycle of each phase; rst_at >= 0 resets in that allocate cycle.
  task automatic miss(input bit d, input int nwb, input int nal, input int rst_at);
    cyc(1'b0, 1'b1, 1'b0, d, rb(), mk(1, 0, 0, 0, 0), "detect");
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (d) begin
      for (int i = 0; i < nwb; i++) begin
        if (i >= int'(TMO)) exp_err = 1'b1;
        cyc(1'b0, rb(), rb(), rb(), i == nwb - 1, mk(1, 1, 1, 1, 0), "writeback");
      end
      cyc(1'b0, rb(), rb(), rb(), rb(), mk(1, 0, 0, 0, 0), "turn");
    end
    for (int i = 0; i < nal; i++) begin
      if (i >= int'(TMO)) exp_err = 1'b1;
      if (i == rst_at) begin
        cyc(1'b1, rb(), rb(), rb(), 1'b0, mk(1, 1, 0, 0, 0), "reset_in_allocate");
        exp_err = 1'b0;
        exp_cnt = 0;
        cyc(1'b0, 1'b0, rb(), rb(), 1'b0, mk(0, 0, 0, 0, 0), "after_reset");
        return;
      end
      cyc(1'b0, rb(), rb(), rb(), i == nal - 1, mk(1, 1, 0, 0, 0), "allocate");
    end
    cyc(1'b0, rb(), rb(), rb(), rb(), mk(1, 0, 0, 0, 1), "refill");
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    hit   = 1'b0;
    dirty = 1'b0;
    ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "reset_state");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b1, rb(), 1'b0, mk(0, 0, 0, 0, 0), "hit");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, rb(), rb(), 1'b1, mk(0, 0, 0, 0, 0), "spurious_ack");

    miss(1'b0, 0, 4, -1);
    idle_cyc(1'b1, "idle_after_clean");
    miss(1'b1, 3, 2, -1);
    idle_cyc(1'b1, "idle_after_dirty");
    miss(1'b0, 0, 10, -1);
    for (int i = 0; i < 3; i++) idle_cyc(1'b1, "error_sticky");
    miss(1'b1, 2, 5, 2);
    idle_cyc(1'b0, "idle_after_reset");

    for (int k = 0; k < 40; k++) begin
      bit d;
      int nwb, nal, ra;
      d   = rb();
      nwb = ($urandom_range(0, 5) == 0) ? 6 : int'($urandom_range(1, 4));
      nal = ($urandom_range(0, 5) == 0) ? 7 : int'($urandom_range(1, 4));
      ra  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      miss(d, nwb, nal, ra);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) idle_cyc(1'b1, "idle_random");
    end
    idle_cyc(1'b1, "idle_final");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
Miss-handling controller for the data-memory stage of the 5-stage pipeline. It watches the MEM-stage access and the cache hit/dirty flags. On a miss it sequences an optional dirty-line writeback and a line allocate over the off-chip memory handshake. While the miss is serviced it holds stall_o high to freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ack_i in one transaction before flagging an error
CNT_W, 32, width of the miss performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
mem_req_i  in  1  MEM stage performs a load or store this cycle (MemRead|MemWrite)
hit_i  in  1  cache tag match and valid for the current MEM-stage address
dirty_i  in  1  victim line is dirty
mem_ack_i  in  1  off-chip memory completes the current transaction (one-cycle pulse)
stall_o  out  1  freeze all pipeline registers (drives their stall_i)
mem_enable_o  out  1  off-chip request valid, level-held until ack
mem_write_o  out  1  1 = writeback of victim, 0 = line read
victim_sel_o  out  1  1 = off-chip address from victim tag, 0 = from MEM-stage address
cache_we_o  out  1  write refilled line plus tag into cache, clear dirty, set valid
error_o  out  1  sticky: a transaction exceeded TIMEOUT
miss_cnt_o  out  CNT_W  number of misses accepted since reset

Behaviour:
- States: IDLE, WRITEBACK, TURN, ALLOCATE, REFILL. Encoding is a 3-bit state enum.
- Reset (synchronous, rst_i=1 at a rising edge), including mid-transaction:
  - state goes to IDLE; error_o=0; miss_cnt_o=0; timeout counter=0.
  - All other outputs are 0 in the following cycle.
- stall_o = (state!=IDLE) | (state==IDLE & mem_req_i & ~hit_i).
  - The IDLE term is combinational (Mealy), so MEM_WB never captures a missing load in its miss cycle.
- Remaining outputs decode from state (Moore):
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, victim_sel_o=1.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, victim_sel_o=0.
  - REFILL: cache_we_o=1 for exactly one cycle.
  - IDLE and TURN: all of these outputs 0.
- Transitions:
  - IDLE: on mem_req_i & ~hit_i, go to WRITEBACK if dirty_i, else ALLOCATE; miss_cnt_o increments by 1. Otherwise stay in IDLE.
  - WRITEBACK: on mem_ack_i go to TURN; otherwise stay.
  - TURN: one cycle with mem_enable_o=0, so two requests are never back-to-back; then go to ALLOCATE.
  - ALLOCATE: on mem_ack_i go to REFILL; otherwise stay.
  - REFILL: go to IDLE. In that next cycle the cache re-looks-up and hits, and stall_o falls.
- Latency:
  - Clean miss: stall_o high for 1 (IDLE detect) + N_alloc + 1 (REFILL) cycles, where N_alloc counts cycles in ALLOCATE including the ack cycle.
  - Dirty miss: additionally N_wb cycles in WRITEBACK plus 1 cycle in TURN.
- mem_ack_i is ignored in IDLE, TURN and REFILL.
- Changes in mem_req_i, hit_i or dirty_i after leaving IDLE are ignored. The transaction always runs to completion.
- Timeout:
  - A counter clears on entry to WRITEBACK or ALLOCATE and increments each cycle in those states without an ack.
  - When it reaches TIMEOUT, error_o sets (sticky until reset). The FSM keeps waiting; no abort.
- Miss counter wraps modulo 2^CNT_W.
- hit_i=1 with mem_req_i=1 in IDLE: no stall, no state change.
- mem_req_i=0: hit_i and dirty_i are don't-care.

Decomposition:
- Shared package (pipeline_pkg): state enum dcache_state_t and the default TIMEOUT constant.
- One natural sub-module: dcache_timeout_cnt (clear/enable/limit, sticky flag output), reusable for the instruction-side controller.
- FSM and miss counter stay in the top module.

Test Plan:
- Hit: mem_req_i=1, hit_i=1 for 5 cycles -> stall_o=0 throughout, mem_enable_o=0, miss_cnt_o=0.
- Clean miss: mem_req_i=1, hit_i=0, dirty_i=0; mem_ack_i pulses in the 4th ALLOCATE cycle -> stall_o high for 6 cycles (1+4+1); mem_write_o=0; cache_we_o high once in cycle 6; miss_cnt_o=1.
- Dirty miss: dirty_i=1; ack after 3 WRITEBACK cycles, then after 2 ALLOCATE cycles -> sequence WRITEBACK(write=1, victim_sel=1) x3, TURN (enable=0) x1, ALLOCATE x2, REFILL x1; stall_o high for 8 cycles.
- Timeout: TIMEOUT=4, miss with no ack for 10 cycles -> error_o rises after 4 waiting cycles and stays 1; a later ack still completes to REFILL then IDLE.
- Reset mid-ALLOCATE: rst_i=1 for one cycle -> next cycle state IDLE, stall_o=0 (with mem_req_i=0), mem_enable_o=0, miss_cnt_o=0, error_o=0.
- Spurious ack: mem_ack_i=1 in IDLE with no miss -> no state change, no outputs asserted.
